note_track_reader: RTL
======================

NOTE_TRACK_READER -- requirements
Module: note_track_reader

Interface
REQ-001 Parameter SONG_LEN, 90, number of playable song-ROM entries, indices 0..SONG_LEN-1.
REQ-002 Parameter DEPTH, 8, rows in the scrolling track buffer; the last row is the judge row.
REQ-003 Parameter HIT_PTS, 10, base points per correct hit.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a song from IDLE.
REQ-007 beat_tick  in  1  one-cycle pulse; one note step per tick.
REQ-008 addr  out  7  song-ROM index, registered; connects to the ROM `go` input.
REQ-009 rom_data  in  5  ROM note row; valid 1 clk after addr changes, because the ROM output is registered.
REQ-010 buttons  in  5  fret levels, already synchronised; bit i = lane i.
REQ-011 strum  in  1  one-cycle pulse; player commits the current buttons value.
REQ-012 track  out  5*DEPTH  buffer rows; row 0 (newest) is bits [4:0].
REQ-013 hit_row  out  5  equals row DEPTH-1 of track.
REQ-014 score  out  16  accumulated points.
REQ-015 streak  out  8  consecutive correct hits.
REQ-016 hit / miss  out  1 each  one-cycle judgement pulses.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at song end.

Function
REQ-019 FSM states:
- IDLE: start -> WAIT_TICK; step=0; clears track, score, streak and judged.
- WAIT_TICK: beat_tick -> ADDR; addr <= step when step<SONG_LEN, otherwise addr holds.
- ADDR: one cycle, unconditional -> CAPTURE.
- CAPTURE: shift and step++; then DONE if step==SONG_LEN+DEPTH-1, else WAIT_TICK.
- DONE: done=1 for one cycle -> IDLE.
REQ-020 Tick-to-capture latency SHALL be exactly 2 clk.
REQ-021 beat_tick outside WAIT_TICK SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-022 Shift in CAPTURE: row k <= row k-1 for k>=1; row 0 <= rom_data when the fetched step<SONG_LEN, else 5'b0 (drain).
REQ-023 Each shift clears judged; if the outgoing hit_row != 0 and judged==0, assert miss and set streak=0.
REQ-024 Strum in any busy state is judged against the pre-shift hit_row:
- hit_row==0 or judged==1: miss, streak=0, no score change.
- buttons==hit_row: hit, judged=1, score += HIT_PTS when streak<10, else 2*HIT_PTS, then streak++.
- otherwise: miss, judged=1, streak=0.
REQ-025 A strum in the CAPTURE cycle that judges the outgoing row SHALL suppress the shift miss for that row; at most one hit or miss pulse per cycle.
REQ-026 score SHALL saturate at 16'hFFFF; streak SHALL saturate at 255.
REQ-027 A strum while IDLE SHALL be ignored; score and streak hold after DONE until the next start.

Reset
REQ-028 rst_n=0 at any clock edge, including mid-song, SHALL force IDLE and set all outputs to 0: addr, track, score, streak, hit, miss, done, busy.

Structure
REQ-029 The shared package track_pkg SHALL hold the state enum, NOTE_W=5 and the streak bonus threshold of 10.
REQ-030 Judging (REQ-024..026) SHALL live in the sub-module note_judge; the FSM, step counter and buffer stay in the top module.

Verification
REQ-031 Reset then start, single tick: addr=0 one clk after the tick; track[4:0]=rom[0] two clk after the tick.
REQ-032 Stub ROM with all entries 5'b00001 and DEPTH=8: after 8 ticks hit_row=00001; strum with buttons=00001 -> hit, score=10, streak=1.
REQ-033 No strums across a full song -> one miss per nonzero row; final score=0, streak=0, done pulse after SONG_LEN+DEPTH ticks.
REQ-034 Eleven consecutive correct hits -> score=10*10+20=120, streak=11; then a wrong strum -> miss, streak=0, score=120.
REQ-035 Strum in the CAPTURE cycle matching the outgoing row -> hit only, no miss; a second strum on the same row -> miss.
REQ-036 rst_n low for one clk at step 40 -> IDLE, all outputs 0; a later start replays from addr=0.

Source files
------------

// File: rtl/track_pkg.sv
// Shared definitions for the note track reader.
// Holds the sequencer state encoding, the note row width, the streak length at
// which the hit bonus starts, and a saturating score adder.
package track_pkg;

    localparam int NOTE_W          = 5;
    localparam int STREAK_BONUS_TH = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_ADDR      = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Add two 16-bit values, clamping at 16'hFFFF instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/note_judge.sv
// Judges player strums against the row currently sitting in the judge row and
// keeps score and streak.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_clear         start of a new song: zero score, streak and judged flag
//   i_strum         strum qualified by the sequencer being busy
//   i_shift         the buffer shifts this cycle (judge row leaves)
//   i_buttons       fret levels committed by the strum
//   i_hit_row       judge row before any shift in this cycle
//   o_score         accumulated points (saturating)
//   o_streak        consecutive correct hits (saturating)
//   o_hit, o_miss   one-cycle judgement pulses
module note_judge
    import track_pkg::*;
#(
    parameter int HIT_PTS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_strum,
    input  logic              i_shift,
    input  logic [NOTE_W-1:0] i_buttons,
    input  logic [NOTE_W-1:0] i_hit_row,
    output logic [15:0]       o_score,
    output logic [7:0]        o_streak,
    output logic              o_hit,
    output logic              o_miss
);

    localparam logic [15:0] LP_PTS       = 16'(HIT_PTS);
    localparam logic [15:0] LP_BONUS_PTS = 16'(2 * HIT_PTS);
    localparam logic [7:0]  LP_STREAK_TH = 8'(STREAK_BONUS_TH);

    logic [15:0] r_score, w_score_n;
    logic [7:0]  r_streak, w_streak_n;
    logic        r_judged, w_judged_n;
    logic        r_hit, w_hit_n;
    logic        r_miss, w_miss_n;

    // Next-state judgement. A strum always takes priority over the shift miss,
    // so a strum on the outgoing row is the only verdict for that row.
    always_comb begin
        w_score_n  = r_score;
        w_streak_n = r_streak;
        w_judged_n = r_judged;
        w_hit_n    = 1'b0;
        w_miss_n   = 1'b0;
        if (i_clear) begin
            w_score_n  = 16'd0;
            w_streak_n = 8'd0;
            w_judged_n = 1'b0;
        end else begin
            if (i_strum) begin
                if ((i_hit_row == {NOTE_W{1'b0}}) || r_judged) begin
                    w_miss_n   = 1'b1;
                    w_streak_n = 8'd0;
                end else if (i_buttons == i_hit_row) begin
                    w_hit_n    = 1'b1;
                    w_judged_n = 1'b1;
                    w_score_n  = sat_add16(r_score,
                                    (r_streak < LP_STREAK_TH) ? LP_PTS : LP_BONUS_PTS);
                    w_streak_n = (r_streak == 8'hFF) ? 8'hFF : (r_streak + 8'd1);
                end else begin
                    w_miss_n   = 1'b1;
                    w_judged_n = 1'b1;
                    w_streak_n = 8'd0;
                end
            end else if (i_shift && (i_hit_row != {NOTE_W{1'b0}}) && !r_judged) begin
                w_miss_n   = 1'b1;
                w_streak_n = 8'd0;
            end else begin
                w_miss_n   = 1'b0;
            end
            // A new row enters the judge position, so it starts unjudged.
            if (i_shift) begin
                w_judged_n = 1'b0;
            end else begin
                w_judged_n = w_judged_n;
            end
        end
    end

    // Judgement state and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_score  <= 16'd0;
            r_streak <= 8'd0;
            r_judged <= 1'b0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_score  <= w_score_n;
            r_streak <= w_streak_n;
            r_judged <= w_judged_n;
            r_hit    <= w_hit_n;
            r_miss   <= w_miss_n;
        end
    end

    assign o_score  = r_score;
    assign o_streak = r_streak;
    assign o_hit    = r_hit;
    assign o_miss   = r_miss;

endmodule

// File: rtl/note_track_reader.sv
// Reads a song from a registered ROM one step per beat tick and scrolls the
// notes through a DEPTH-row buffer; the oldest row is the judge row.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a song (only from IDLE)
//   beat_tick         advance one note step (only in WAIT_TICK)
//   addr              registered ROM index
//   rom_data          ROM row, one clock behind addr
//   buttons, strum    player input
//   track             buffer rows, row 0 in bits [4:0]
//   hit_row           judge row (row DEPTH-1)
//   score, streak     scoring state
//   hit, miss         judgement pulses
//   busy, done        sequencer status
module note_track_reader
    import track_pkg::*;
#(
    parameter int SONG_LEN = 90,
    parameter int DEPTH    = 8,
    parameter int HIT_PTS  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    beat_tick,
    output logic [6:0]              addr,
    input  logic [NOTE_W-1:0]       rom_data,
    input  logic [NOTE_W-1:0]       buttons,
    input  logic                    strum,
    output logic [NOTE_W*DEPTH-1:0] track,
    output logic [NOTE_W-1:0]       hit_row,
    output logic [15:0]             score,
    output logic [7:0]              streak,
    output logic                    hit,
    output logic                    miss,
    output logic                    busy,
    output logic                    done
);

    localparam logic [7:0] LP_SONG_LEN  = 8'(SONG_LEN);
    localparam logic [7:0] LP_LAST_STEP = 8'(SONG_LEN + DEPTH - 1);

    state_e                  r_state, w_next;
    logic                    w_clear, w_capture;
    logic [7:0]              r_step;
    logic [6:0]              r_addr;
    logic [NOTE_W*DEPTH-1:0] r_track;
    logic [NOTE_W-1:0]       w_row0, w_hit_row;
    logic                    w_strum_en;
    logic                    r_busy, r_done;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sequencer next state and datapath strobes.
    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next  = ST_WAIT_TICK;
                    w_clear = 1'b1;
                end else begin
                    w_next  = ST_IDLE;
                end
            end
            ST_WAIT_TICK: begin
                if (beat_tick) begin
                    w_next = ST_ADDR;
                end else begin
                    w_next = ST_WAIT_TICK;
                end
            end
            // The ROM registers addr during this cycle.
            ST_ADDR: begin
                w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_capture = 1'b1;
                if (r_step == LP_LAST_STEP) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_WAIT_TICK;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Past the end of the song the buffer drains with empty rows.
    always_comb begin
        if (r_step < LP_SONG_LEN) begin
            w_row0 = rom_data;
        end else begin
            w_row0 = {NOTE_W{1'b0}};
        end
    end

    assign w_hit_row  = r_track[NOTE_W*DEPTH-1 -: NOTE_W];
    assign w_strum_en = strum && (r_state != ST_IDLE);

    // Step counter, ROM address and scrolling buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step  <= 8'd0;
            r_addr  <= 7'd0;
            r_track <= {(NOTE_W*DEPTH){1'b0}};
        end else begin
            if (w_clear) begin
                r_step  <= 8'd0;
                r_track <= {(NOTE_W*DEPTH){1'b0}};
            end else if (w_capture) begin
                r_step  <= r_step + 8'd1;
                r_track <= {r_track[NOTE_W*(DEPTH-1)-1:0], w_row0};
            end else begin
                r_step  <= r_step;
                r_track <= r_track;
            end
            // During drain the address stays on the last song entry.
            if ((r_state == ST_WAIT_TICK) && beat_tick && (r_step < LP_SONG_LEN)) begin
                r_addr <= r_step[6:0];
            end else begin
                r_addr <= r_addr;
            end
        end
    end

    // Status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE);
        end
    end

    note_judge #(
        .HIT_PTS (HIT_PTS)
    ) u_judge (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_strum   (w_strum_en),
        .i_shift   (w_capture),
        .i_buttons (buttons),
        .i_hit_row (w_hit_row),
        .o_score   (score),
        .o_streak  (streak),
        .o_hit     (hit),
        .o_miss    (miss)
    );

    assign addr    = r_addr;
    assign track   = r_track;
    assign hit_row = w_hit_row;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
